param_updown_ctr: RTL and testbench

PARAM_UPDOWN_CTR -- requirements
Module: param_updown_ctr

---
 rtl/param_updown_ctr_pkg.sv | 17 +
 rtl/param_updown_ctr_next_val.sv | 48 ++++
 rtl/param_updown_ctr.sv | 71 +++++++
 tb/tb_param_updown_ctr.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_updown_ctr_pkg.sv
// Shared constants and types for the parameterised up/down counter.
// Direction and mode encodings are used by both the counter and its next-value logic.
package param_updown_ctr_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    EVT_OVF  = 2'd1,
    EVT_UNF  = 2'd2
  } bnd_evt_e;

endpackage

// File: rtl/param_updown_ctr_next_val.sv
// Stateless next-count and boundary-event logic for param_updown_ctr.
// Load beats count; the count clamps or wraps at 0 / MAX_VAL depending on SATURATE.
module ctr_next_val
  import param_updown_ctr_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] ctr_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] l_data_i,
  output logic [WIDTH-1:0] ctr_next_o,
  output bnd_evt_e         evt_o
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam bit               SAT  = (SATURATE == MODE_SAT);

  always_comb begin
    ctr_next_o = ctr_i;
    evt_o      = EVT_NONE;
    if (load_i) begin
      // Out-of-range load values are clamped so the count never exceeds MAX_VAL.
      ctr_next_o = (l_data_i > MAX_VAL) ? MAX_VAL : l_data_i;
    end else if (en_i) begin
      if (dir_i == DIR_UP) begin
        if (ctr_i == MAX_VAL) begin
          evt_o      = EVT_OVF;
          ctr_next_o = SAT ? MAX_VAL : ZERO;
        end else begin
          ctr_next_o = ctr_i + ONE;
        end
      end else begin
        if (ctr_i == ZERO) begin
          evt_o      = EVT_UNF;
          ctr_next_o = SAT ? ZERO : MAX_VAL;
        end else begin
          ctr_next_o = ctr_i - ONE;
        end
      end
    end
  end

endmodule

// File: rtl/param_updown_ctr.sv
// Parameterised up/down counter with load, wrap/saturate modes, a boundary pulse
// and sticky overflow/underflow flags. All state lives here; next-value logic is in ctr_next_val.
module param_updown_ctr
  import param_updown_ctr_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] l_data,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] ctr,
  output logic             tc,
  output logic             wrap_p,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] ctr_q, ctr_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  bnd_evt_e         evt;

  ctr_next_val #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .ctr_i      (ctr_q),
    .en_i       (en),
    .dir_i      (dir),
    .load_i     (load),
    .l_data_i   (l_data),
    .ctr_next_o (ctr_d),
    .evt_o      (evt)
  );

  // A fresh event outranks a same-cycle flag clear.
  always_comb begin
    wrap_d = (evt != EVT_NONE);
    ovf_d  = (evt == EVT_OVF) | (ovf_q & ~clr_flags);
    unf_d  = (evt == EVT_UNF) | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctr_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      ctr_q  <= ctr_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign ctr    = ctr_q;
  assign wrap_p = wrap_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign tc     = (dir == DIR_UP) ? (ctr_q == MAX_VAL) : (ctr_q == '0);

endmodule

// File: tb/tb_param_updown_ctr.sv
// Bench for param_updown_ctr: three configurations driven in lockstep by directed vectors,
// checked every cycle against an arithmetic model plus hand-computed literal expectations.
module tb_param_updown_ctr;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] l_data;
  logic       clr_flags;

  logic [3:0] ctr_a;
  logic [3:0] ctr_b;
  logic [2:0] ctr_c;
  logic       tc_w   [3];
  logic       wrap_w [3];
  logic       ovf_w  [3];
  logic       unf_w  [3];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Instance 0: MAX 9 wrap; 1: MAX 9 saturate; 2: WIDTH 3 with default MAX (7), wrap.
  param_updown_ctr #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .l_data(l_data),
    .clr_flags(clr_flags), .ctr(ctr_a), .tc(tc_w[0]), .wrap_p(wrap_w[0]),
    .ovf(ovf_w[0]), .unf(unf_w[0]));

  param_updown_ctr #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .l_data(l_data),
    .clr_flags(clr_flags), .ctr(ctr_b), .tc(tc_w[1]), .wrap_p(wrap_w[1]),
    .ovf(ovf_w[1]), .unf(unf_w[1]));

  param_updown_ctr #(.WIDTH(3)) dut_c (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .l_data(l_data[2:0]),
    .clr_flags(clr_flags), .ctr(ctr_c), .tc(tc_w[2]), .wrap_p(wrap_w[2]),
    .ovf(ovf_w[2]), .unf(unf_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int   c;
    logic w;
    logic o;
    logic u;
  } mstate_t;

  mstate_t m [3];

  function automatic int maxv(int i);
    return (i == 2) ? 7 : 9;
  endfunction

  function automatic bit satv(int i);
    return (i == 1);
  endfunction

  function automatic int ldv(int i, logic [3:0] v);
    return (i == 2) ? (int'(v) % 8) : int'(v);
  endfunction

  function automatic int dut_ctr(int i);
    case (i)
      0:       return int'(ctr_a);
      1:       return int'(ctr_b);
      default: return int'(ctr_c);
    endcase
  endfunction

  // Counting is modular arithmetic over 0..mx, or clamped arithmetic when saturating.
  function automatic mstate_t mnext(mstate_t s, int mx, bit sat, logic ld, logic e,
                                    logic d, int lv, logic clr);
    mstate_t n;
    n   = s;
    n.w = 1'b0;
    if (clr) begin
      n.o = 1'b0;
      n.u = 1'b0;
    end
    if (ld) begin
      n.c = (lv > mx) ? mx : lv;
    end else if (e && d) begin
      if (s.c + 1 > mx) begin
        n.o = 1'b1;
        n.w = 1'b1;
      end
      n.c = sat ? ((s.c + 1 > mx) ? mx : s.c + 1) : (s.c + 1) % (mx + 1);
    end else if (e) begin
      if (s.c - 1 < 0) begin
        n.u = 1'b1;
        n.w = 1'b1;
      end
      n.c = sat ? ((s.c - 1 < 0) ? 0 : s.c - 1) : (s.c + mx) % (mx + 1);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) m[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        m[i] <= mnext(m[i], maxv(i), satv(i), load, en, dir, ldv(i, l_data), clr_flags);
    end
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("ctr", i, dut_ctr(i), m[i].c);
        chk("tc", i, int'(tc_w[i]), int'(dir ? (m[i].c == maxv(i)) : (m[i].c == 0)));
        chk("wrap_p", i, int'(wrap_w[i]), int'(m[i].w));
        chk("ovf", i, int'(ovf_w[i]), int'(m[i].o));
        chk("unf", i, int'(unf_w[i]), int'(m[i].u));
      end
    end
  end

  // Literal expectation checked against both the DUT and the model.
  task automatic pin(input int i, input int c, input bit w, input bit o, input bit u);
    chk("lit_ctr", i, dut_ctr(i), c);
    chk("lit_wrap", i, int'(wrap_w[i]), int'(w));
    chk("lit_ovf", i, int'(ovf_w[i]), int'(o));
    chk("lit_unf", i, int'(unf_w[i]), int'(u));
    chk("model_ctr", i, m[i].c, c);
    chk("model_flags", i, int'({m[i].w, m[i].o, m[i].u}), int'({w, o, u}));
  endtask

  task automatic step(input logic ld, input logic e, input logic d, input logic [3:0] v,
                      input logic clr);
    load      = ld;
    en        = e;
    dir       = d;
    l_data    = v;
    clr_flags = clr;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; l_data = 4'd0; clr_flags = 1'b0;
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) pin(i, 0, 0, 0, 0);
    chk("tc_in_reset", 0, int'(tc_w[0]), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Count up 12 edges: wrap instance goes 1..9,0,1,2; saturating one holds at 9.
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      pin(0, k % 10, k == 10, k >= 10, 0);
      pin(1, (k < 9) ? k : 9, k >= 10, k >= 10, 0);
      if (k == 9) chk("tc_at_max", 0, int'(tc_w[0]), 1);
    end

    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    pin(0, 0, 0, 1, 0);
    chk("tc_down_at_zero", 0, int'(tc_w[0]), 1);

    step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    pin(0, 9, 1, 1, 1);
    pin(1, 0, 1, 1, 1);
    pin(2, 7, 1, 1, 1);

    step(1'b1, 1'b0, 1'b1, 4'd15, 1'b0);
    pin(0, 9, 0, 1, 1);
    pin(1, 9, 0, 1, 1);
    pin(2, 7, 0, 1, 1);

    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
      pin(1, 9, 1, 1, 1);
      pin(0, k - 1, k == 1, 1, 1);
    end

    step(1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
    pin(0, 9, 0, 0, 0);
    pin(1, 9, 0, 0, 0);
    pin(2, 1, 0, 0, 0);

    // Load at the boundary with en/dir asserted: no event.
    step(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
    pin(0, 3, 0, 0, 0);
    pin(1, 3, 0, 0, 0);

    step(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    pin(0, 5, 0, 0, 0);

    // Asynchronous reset between edges with a pending load.
    rst = 1'b0; load = 1'b1; l_data = 4'd7; en = 1'b1; dir = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) pin(i, 0, 0, 0, 0);
    chk("tc_async_reset", 0, int'(tc_w[0]), 1);
    @(posedge clk);
    #2;
    pin(0, 0, 0, 0, 0);
    rst = 1'b1; load = 1'b0; en = 1'b1; dir = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) pin(i, 1, 0, 0, 0);

    // Flag clear loses to a coincident overflow, then clears on its own.
    step(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    pin(0, 0, 1, 1, 0);
    step(1'b1, 1'b0, 1'b1, 4'd9, 1'b0);
    pin(0, 9, 0, 1, 0);
    step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    pin(0, 0, 1, 1, 0);
    pin(1, 9, 1, 1, 0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
    pin(0, 0, 0, 0, 0);
    pin(1, 9, 0, 0, 0);
    pin(2, 2, 0, 0, 0);

    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
